cp0_ctrl: RTL
=============

Name: cp0_ctrl

Overview:
- Parametrised System Control Coprocessor for the MIPS pipeline.
- Holds the architected CP0 state: BadVAddr, Count, Compare, Status, Cause and EPC.
- Provides an MTC0/MFC0 access port, plus a commit-stage exception/ERET interface.
- Generates the registered interrupt request consumed by the commit stage and the EPC redirect target.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines; maps to Cause.IP[2 +: NUM_HW_INT]; legal range 1..6.
- COUNT_DIV, 2, clock cycles per Count increment; legal range 1..16.
- EPC_BD_OFFSET, 4, bytes subtracted from exc_pc when the excepting instruction is in a delay slot.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wen  in  1  MTC0 write strobe.
- addr  in  8  {reg[4:0], sel[2:0]}; only sel=0 is implemented.
- wdata  in  32  MTC0 write data.
- rdata  out  32  MFC0 read data; combinational from addr.
- hw_int  in  NUM_HW_INT  level-sensitive external interrupts; registered once internally.
- exc_valid  in  1  exception committed this cycle.
- exc_code  in  5  ExcCode value.
- exc_bd  in  1  excepting instruction is in a delay slot.
- exc_pc  in  32  PC of the excepting instruction.
- exc_badvaddr  in  32  faulting address.
- eret  in  1  ERET committed this cycle.
- epc_out  out  32  current EPC value.
- status_exl  out  1  Status.EXL.
- int_req  out  1  registered interrupt request.

Behaviour:
- Reset values (asynchronous, all registers):
  - Status = 0x0040_0000 (BEV=1).
  - Cause, Count, Compare, EPC, BadVAddr = 0.
  - int_req = 0, status_exl = 0, epc_out = 0.
  - Internal divider = 0; hw_int sync register = 0.
- Register map (reg number): BadVAddr 8 (RO), Count 9, Compare 11, Status 12, Cause 13, EPC 14.
  - Any other reg, or sel != 0: reads 0, writes ignored.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. BEV[22] reads 1. All other bits read 0.
  - Cause: IP[9:8] (software interrupts) only.
    - BD[31], TI[30], IP[15:10] and ExcCode[6:2] are read-only.
    - IP[15:10] reflects registered hw_int. Unused lines read 0.
  - EPC, Count, Compare: fully writable.
- Read path:
  - rdata reflects the current register content with zero write-through.
  - A same-cycle write is visible on the next cycle.
- Count:
  - Increments by 1 every COUNT_DIV cycles and wraps 0xFFFF_FFFF -> 0.
  - An MTC0 to Count loads wdata and resets the divider phase to 0.
- Timer interrupt:
  - Cause.TI sets on the cycle after Count == Compare.
  - Any MTC0 to Compare clears TI; if a clear and a set coincide, the clear wins.
  - Cause.IP[7] = hw_int[5] | TI (hw_int[5] only when NUM_HW_INT = 6).
- int_req:
  - Registered each cycle as Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
  - Latency: one cycle from the causing register change.
- Exception (exc_valid = 1):
  - ExcCode <= exc_code; EXL <= 1.
  - If EXL was 0: EPC <= exc_bd ? exc_pc - EPC_BD_OFFSET : exc_pc, and BD <= exc_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - If exc_code is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr.
- ERET: EXL <= 0.
- Priority within one cycle: exc_valid > eret > wen.
  - A wen arriving with exc_valid or eret is dropped entirely, including to unrelated registers.
- Reset asserted mid-operation: all state returns immediately to reset values; a pending TI or int_req is lost.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as specified above.
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - TI is constant 0; Cause.IP[7] = hw_int[5] only.
  - The divider logic is removed.

Test Plan:
- Reset mid-run → all outputs 0; Status reads 0x0040_0000.
- Write Status = 0x0000_FF03 → reads 0x0040_FF03. Write Cause = 0xFFFF_FFFF → reads 0x0000_0300.
- exc_valid, exc_code=4, exc_bd=1, exc_pc=0xBFC0_0104, badvaddr=0x1234_5679:
  - EPC = 0xBFC0_0100, Cause = 0x8000_0010, BadVAddr = 0x1234_5679, EXL = 1.
  - A second exception, exc_pc=0x8000_0000 → EPC unchanged, ExcCode updated.
- COUNT_DIV=2, write Count=0 and Compare=5:
  - TI = 1 on cycle 11 after the write.
  - With Status = 0x0000_8001, int_req = 1 one cycle later.
  - Write Compare → TI = 0 and int_req = 0 the following cycle.
- Same cycle exc_valid + eret + wen to EPC → EXL = 1 and EPC = exception value; wen dropped.
- Status = 0x0000_0401, hw_int[0] = 1 → int_req = 1 after 2 cycles. Then eret with EXL = 0 → no change; EXL set → int_req = 0.

Source files
------------

// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: MTC0/MFC0 access port plus commit-stage exception/ERET signals of the CP0 block.
// master = pipeline side, slave = cp0_ctrl.
interface cp0_ctrl_if;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] epc_out;
    logic        status_exl;
    logic        int_req;

    modport master (
        output wen, addr, wdata, exc_valid, exc_code, exc_bd, exc_pc, exc_badvaddr, eret,
        input  rdata, epc_out, status_exl, int_req
    );

    modport slave (
        input  wen, addr, wdata, exc_valid, exc_code, exc_bd, exc_pc, exc_badvaddr, eret,
        output rdata, epc_out, status_exl, int_req
    );
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS CP0 state (BadVAddr, Count, Compare, Status, Cause, EPC) with registered int_req.
// Count/Compare and the timer interrupt exist only when CP0_TIMER_EN is defined.
module cp0_ctrl #(
    parameter int NUM_HW_INT    = 6,
    parameter int COUNT_DIV     = 2,
    parameter int EPC_BD_OFFSET = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_HW_INT-1:0] hw_int,
    cp0_ctrl_if.slave             bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_hw_int
        $error("cp0_ctrl: NUM_HW_INT must be 1..6");
    end
    if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_count_div
        $error("cp0_ctrl: COUNT_DIV must be 1..16");
    end

    logic [4:0]            rnum;
    logic [2:0]            sel;
    logic                  wr_en;
    logic [31:0]           badv_q, badv_d, epc_q, epc_d;
    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, int_req_q, int_req_d;
    logic [1:0]            sw_ip_q, sw_ip_d;
    logic [4:0]            code_q, code_d;
    logic [NUM_HW_INT-1:0] hw_q, hw_d;
    logic                  ti;
    logic [31:0]           count_rd, compare_rd, status, cause;
    logic [7:0]            ip;

    assign rnum  = bus.addr[7:3];
    assign sel   = bus.addr[2:0];
    // Exceptions and ERET own the commit slot; a coincident MTC0 is discarded wholesale.
    assign wr_en = bus.wen & ~bus.exc_valid & ~bus.eret & (sel == 3'd0);

    always_comb begin
        ip                  = '0;
        ip[1:0]             = sw_ip_q;
        ip[2 +: NUM_HW_INT] = hw_q;
        ip[7]               = ip[7] | ti;
    end

    assign status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause  = {bd_q, ti, 14'd0, ip, 1'b0, code_q, 2'b00};

    always_comb begin
        bus.rdata = '0;
        if (sel == 3'd0) begin
            case (rnum)
                REG_BADVADDR: bus.rdata = badv_q;
                REG_COUNT:    bus.rdata = count_rd;
                REG_COMPARE:  bus.rdata = compare_rd;
                REG_STATUS:   bus.rdata = status;
                REG_CAUSE:    bus.rdata = cause;
                REG_EPC:      bus.rdata = epc_q;
                default:      bus.rdata = '0;
            endcase
        end
    end

    always_comb begin
        badv_d    = badv_q;
        epc_d     = epc_q;
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        sw_ip_d   = sw_ip_q;
        code_d    = code_q;
        hw_d      = hw_int;
        int_req_d = ie_q & ~exl_q & (|(ip & im_q));
        if (bus.exc_valid) begin
            code_d = bus.exc_code;
            exl_d  = 1'b1;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = bus.exc_bd ? bus.exc_pc - 32'(EPC_BD_OFFSET) : bus.exc_pc;
                bd_d  = bus.exc_bd;
            end
            if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) badv_d = bus.exc_badvaddr;
        end else if (bus.eret) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (rnum)
                REG_STATUS: begin
                    im_d  = bus.wdata[15:8];
                    exl_d = bus.wdata[1];
                    ie_d  = bus.wdata[0];
                end
                REG_CAUSE: sw_ip_d = bus.wdata[9:8];
                REG_EPC:   epc_d   = bus.wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badv_q    <= '0;
            epc_q     <= '0;
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            sw_ip_q   <= '0;
            code_q    <= '0;
            hw_q      <= '0;
            int_req_q <= 1'b0;
        end else begin
            badv_q    <= badv_d;
            epc_q     <= epc_d;
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            sw_ip_q   <= sw_ip_d;
            code_q    <= code_d;
            hw_q      <= hw_d;
            int_req_q <= int_req_d;
        end
    end

`ifdef CP0_TIMER_EN
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d, compare_q, compare_d;
    logic             ti_q, ti_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (wr_en && rnum == REG_COUNT) begin
            count_d = bus.wdata;
            div_d   = '0;
        end else if (div_q == DIV_W'(COUNT_DIV - 1)) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        // Clear takes precedence over a match in the same cycle.
        if (wr_en && rnum == REG_COMPARE) begin
            compare_d = bus.wdata;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    assign bus.epc_out    = epc_q;
    assign bus.status_exl = exl_q;
    assign bus.int_req    = int_req_q;
endmodule
